// File: rtl/cpu_program_loader_if.sv
// Stream and cpu external-memory bundle for cpu_program_loader.
// master = loader side, slave = host stream source / cpu memory side.
interface cpu_program_loader_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  logic [31:0]       imem_addr;
  logic              imem_wen;
  logic              imem_ren;
  logic [DATA_W-1:0] imem_wdata;
  logic [DATA_W-1:0] imem_rdata;

  logic [31:0]       dmem_addr;
  logic              dmem_wen;
  logic              dmem_ren;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    input  s_valid, s_data, imem_rdata, dmem_rdata,
    output s_ready,
    output imem_addr, imem_wen, imem_ren, imem_wdata,
    output dmem_addr, dmem_wen, dmem_ren, dmem_wdata
  );

  modport slave (
    output s_valid, s_data, imem_rdata, dmem_rdata,
    input  s_ready,
    input  imem_addr, imem_wen, imem_ren, imem_wdata,
    input  dmem_addr, dmem_wen, dmem_ren, dmem_wdata
  );
endinterface

// File: rtl/cpu_program_loader.sv
// Boot loader: streams IMEM/DMEM images into the cpu ext ports, then enables the cpu.
// Optional readback check of both memories when LOADER_VERIFY_EN is defined.
module cpu_program_loader #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic                  stop,
  cpu_program_loader_if.master  bus,
  output logic                  cpu_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int MAX_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_I,
    S_LOAD_I,
    S_HDR_D,
    S_LOAD_D,
`ifdef LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_RUN,
    S_ERROR
  } state_t;

`ifdef LOADER_VERIFY_EN
  localparam state_t S_AFTER_D = S_VERIFY;
  localparam int     VW        = CNT_W + 1;
`else
  localparam state_t S_AFTER_D = S_RUN;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] csum_i_q, csum_i_d;
  logic [DATA_W-1:0] csum_d_q, csum_d_d;
  logic              done_q, done_d;
  logic              run_seen_q, run_seen_d;
  logic              cpu_enable_q, cpu_enable_d;

`ifdef LOADER_VERIFY_EN
  logic [CNT_W-1:0]  cnt_i_q, cnt_i_d;
  logic [CNT_W-1:0]  cnt_d_q, cnt_d_d;
  logic [VW-1:0]     vidx_q, vidx_d;
  logic              rd_i_q, rd_i_d;
  logic              rd_d_q, rd_d_d;
  logic [DATA_W-1:0] rb_i_q, rb_i_d;
  logic [DATA_W-1:0] rb_d_q, rb_d_d;
  logic [VW-1:0]     v_total;
  logic [VW-1:0]     v_didx;
`endif

  logic              s_ready;
  logic [31:0]       imem_addr, dmem_addr;
  logic              imem_wen, dmem_wen, imem_ren, dmem_ren;
  logic [DATA_W-1:0] imem_wdata, dmem_wdata;
  logic [31:0]       byte_addr;

  assign byte_addr = 32'({addr_q, 2'b00});

`ifdef LOADER_VERIFY_EN
  assign v_total = VW'(cnt_i_q) + VW'(cnt_d_q);
  assign v_didx  = vidx_q - VW'(cnt_i_q);
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    csum_i_d     = csum_i_q;
    csum_d_d     = csum_d_q;
    done_d       = 1'b0;
    run_seen_d   = (state_q == S_RUN);
    cpu_enable_d = 1'b0;
    s_ready      = 1'b0;
    imem_addr    = '0;
    imem_wen     = 1'b0;
    imem_ren     = 1'b0;
    imem_wdata   = '0;
    dmem_addr    = '0;
    dmem_wen     = 1'b0;
    dmem_ren     = 1'b0;
    dmem_wdata   = '0;
`ifdef LOADER_VERIFY_EN
    cnt_i_d = cnt_i_q;
    cnt_d_d = cnt_d_q;
    vidx_d  = '0;
    rd_i_d  = 1'b0;
    rd_d_d  = 1'b0;
    rb_i_d  = rb_i_q;
    rb_d_d  = rb_d_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_HDR_I;
          csum_i_d = '0;
          csum_d_d = '0;
`ifdef LOADER_VERIFY_EN
          rb_i_d = '0;
          rb_d_d = '0;
`endif
        end
      end

      S_HDR_I: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
`ifdef LOADER_VERIFY_EN
          cnt_i_d = bus.s_data[CNT_W-1:0];
`endif
          if (bus.s_data > DATA_W'(IMEM_WORDS)) begin
            state_d = S_ERROR;
          end else if (bus.s_data == '0) begin
            state_d = S_HDR_D;
          end else begin
            state_d = S_LOAD_I;
            rem_d   = bus.s_data[CNT_W-1:0];
            addr_d  = '0;
          end
        end
      end

      S_LOAD_I: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          imem_wen   = 1'b1;
          imem_addr  = byte_addr;
          imem_wdata = bus.s_data;
          csum_i_d   = csum_i_q ^ bus.s_data;
          addr_d     = addr_q + 1'b1;
          rem_d      = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = S_HDR_D;
        end
      end

      S_HDR_D: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
`ifdef LOADER_VERIFY_EN
          cnt_d_d = bus.s_data[CNT_W-1:0];
`endif
          if (bus.s_data > DATA_W'(DMEM_WORDS)) begin
            state_d = S_ERROR;
          end else if (bus.s_data == '0) begin
            state_d = S_AFTER_D;
          end else begin
            state_d = S_LOAD_D;
            rem_d   = bus.s_data[CNT_W-1:0];
            addr_d  = '0;
          end
        end
      end

      S_LOAD_D: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          dmem_wen   = 1'b1;
          dmem_addr  = byte_addr;
          dmem_wdata = bus.s_data;
          csum_d_d   = csum_d_q ^ bus.s_data;
          addr_d     = addr_q + 1'b1;
          rem_d      = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = S_AFTER_D;
        end
      end

`ifdef LOADER_VERIFY_EN
      // Reads issue back to back; the two extra cycles drain the last rdata and compare.
      S_VERIFY: begin
        vidx_d = vidx_q + 1'b1;
        if (vidx_q < VW'(cnt_i_q)) begin
          imem_ren  = 1'b1;
          imem_addr = 32'({vidx_q, 2'b00});
          rd_i_d    = 1'b1;
        end else if (vidx_q < v_total) begin
          dmem_ren  = 1'b1;
          dmem_addr = 32'({v_didx, 2'b00});
          rd_d_d    = 1'b1;
        end
        if (rd_i_q) rb_i_d = rb_i_q ^ bus.imem_rdata;
        if (rd_d_q) rb_d_d = rb_d_q ^ bus.dmem_rdata;
        if (vidx_q == v_total + 1'b1) begin
          state_d = (rb_i_q == csum_i_q && rb_d_q == csum_d_q) ? S_RUN : S_ERROR;
        end
      end
`endif

      S_RUN: begin
        done_d       = !run_seen_q && !stop;
        cpu_enable_d = run_seen_q && !stop;
        if (stop) state_d = S_IDLE;
      end

      S_ERROR: begin
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      csum_i_q     <= '0;
      csum_d_q     <= '0;
      done_q       <= 1'b0;
      run_seen_q   <= 1'b0;
      cpu_enable_q <= 1'b0;
`ifdef LOADER_VERIFY_EN
      cnt_i_q <= '0;
      cnt_d_q <= '0;
      vidx_q  <= '0;
      rd_i_q  <= 1'b0;
      rd_d_q  <= 1'b0;
      rb_i_q  <= '0;
      rb_d_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      csum_i_q     <= csum_i_d;
      csum_d_q     <= csum_d_d;
      done_q       <= done_d;
      run_seen_q   <= run_seen_d;
      cpu_enable_q <= cpu_enable_d;
`ifdef LOADER_VERIFY_EN
      cnt_i_q <= cnt_i_d;
      cnt_d_q <= cnt_d_d;
      vidx_q  <= vidx_d;
      rd_i_q  <= rd_i_d;
      rd_d_q  <= rd_d_d;
      rb_i_q  <= rb_i_d;
      rb_d_q  <= rb_d_d;
`endif
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.imem_addr  = imem_addr;
  assign bus.imem_wen   = imem_wen;
  assign bus.imem_ren   = imem_ren;
  assign bus.imem_wdata = imem_wdata;
  assign bus.dmem_addr  = dmem_addr;
  assign bus.dmem_wen   = dmem_wen;
  assign bus.dmem_ren   = dmem_ren;
  assign bus.dmem_wdata = dmem_wdata;

  assign cpu_enable = cpu_enable_q;
  assign done       = done_q;
  assign error      = (state_q == S_ERROR);
  assign busy       = (state_q != S_IDLE) && (state_q != S_RUN) && (state_q != S_ERROR);

endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader: vector table plus write scoreboard and hand-written corner cases.
module tb_cpu_program_loader;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic cpu_enable, busy, done, error;

  cpu_program_loader_if #(.DATA_W(32)) bus ();

  cpu_program_loader dut (
    .clk        (clk),
    .arst       (arst),
    .start      (start),
    .stop       (stop),
    .bus        (bus),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        port;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int ni;
    int nd;
    bit tog;
    bit err;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int first_acc;
  int done_cyc;
  wr_t exp_q[$];
  logic [31:0] stream_q[$];
  bit corrupt_en = 1'b0;

`ifdef LOADER_VERIFY_EN
  localparam int DONE_LAT = 6 + 5;
`else
  localparam int DONE_LAT = 6;
`endif

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // cpu memory model: rdata one cycle after ren, optional single-bit corruption at IMEM addr 4
`ifdef LOADER_VERIFY_EN
  logic [31:0] imem_m [512];
  logic [31:0] dmem_m [1024];
  always @(posedge clk) begin
    if (bus.imem_wen) imem_m[bus.imem_addr[10:2]] <= bus.imem_wdata;
    if (bus.dmem_wen) dmem_m[bus.dmem_addr[11:2]] <= bus.dmem_wdata;
    bus.imem_rdata <= bus.imem_ren ?
      (imem_m[bus.imem_addr[10:2]] ^ {31'b0, corrupt_en && bus.imem_addr == 32'd4}) : 32'h0;
    bus.dmem_rdata <= bus.dmem_ren ? dmem_m[bus.dmem_addr[11:2]] : 32'h0;
  end
`endif

  // write scoreboard
  always @(negedge clk) begin
    wr_t w;
    if (bus.imem_wen || bus.dmem_wen) begin
      wr_cnt++;
      check("wen_only_on_transfer", {31'b0, bus.s_valid && bus.s_ready}, 32'd1);
      check("single_port_write", {31'b0, bus.imem_wen && bus.dmem_wen}, 32'd0);
      check("wen_ren_exclusive", {31'b0, (bus.imem_wen && bus.imem_ren) || (bus.dmem_wen && bus.dmem_ren)}, 32'd0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got imem_wen=%0b dmem_wen=%0b, required no write (cycle %0d)",
                 bus.imem_wen, bus.dmem_wen, cyc);
      end else begin
        w = exp_q.pop_front();
        check("write_port", {31'b0, bus.dmem_wen}, {31'b0, w.port});
        check("write_addr", bus.dmem_wen ? bus.dmem_addr : bus.imem_addr, w.addr);
        check("write_data", bus.dmem_wen ? bus.dmem_wdata : bus.imem_wdata, w.data);
      end
    end
  end

  task automatic do_reset();
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic add_payload(input bit port, input int n, input bit fixed, input logic [31:0] f0, input logic [31:0] f1);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      w = fixed ? ((k == 0) ? f0 : f1) : $urandom;
      stream_q.push_back(w);
      exp_q.push_back('{port, 32'(k * 4), w});
    end
  endtask

  task automatic build_rand(input int ni, input int nd);
    stream_q.delete();
    stream_q.push_back(32'(ni));
    if (ni <= 512) begin
      add_payload(1'b0, ni, 1'b0, 32'h0, 32'h0);
      stream_q.push_back(32'(nd));
      if (nd <= 1024) add_payload(1'b1, nd, 1'b0, 32'h0, 32'h0);
    end
  endtask

  task automatic build_fixed();
    stream_q.delete();
    stream_q.push_back(32'd2);
    add_payload(1'b0, 2, 1'b1, 32'h2008_0005, 32'h2009_0007);
    stream_q.push_back(32'd1);
    add_payload(1'b1, 1, 1'b1, 32'hDEAD_BEEF, 32'h0);
  endtask

  task automatic send(input bit tog);
    int i = 0;
    int g = 0;
    bit v, acc;
    first_acc = -1;
    while (i < stream_q.size() && g < 4000) begin
      v = tog ? (g % 2 == 0) : 1'b1;
      bus.s_valid = v;
      bus.s_data  = stream_q[i];
      @(negedge clk);
      acc = v && bus.s_ready;
      if (acc && first_acc < 0) first_acc = cyc;
      @(posedge clk); #1;
      if (acc) i++;
      g++;
    end
    bus.s_valid = 1'b0;
    bus.s_data  = 32'h0;
    check("stream_drained", 32'(i), 32'(stream_q.size()));
  endtask

  task automatic finish_load(input bit exp_err);
    bit got = 1'b0;
    logic en_at_done = 1'b0;
    for (int g = 0; g < 3000 && !got; g++) begin
      @(negedge clk);
      if (done || error) begin
        got = 1'b1;
        done_cyc = cyc;
        en_at_done = cpu_enable;
      end
    end
    check("outcome_seen", {31'b0, got}, 32'd1);
    check("error_flag", {31'b0, error}, {31'b0, exp_err});
    if (exp_err) begin
      check("err_s_ready", {31'b0, bus.s_ready}, 32'd0);
      check("err_cpu_enable", {31'b0, cpu_enable}, 32'd0);
      check("err_busy", {31'b0, busy}, 32'd0);
    end else begin
      check("enable_low_at_done", {31'b0, en_at_done}, 32'd0);
      @(negedge clk);
      check("cpu_enable_after_done", {31'b0, cpu_enable}, 32'd1);
      check("done_is_pulse", {31'b0, done}, 32'd0);
      check("busy_in_run", {31'b0, busy}, 32'd0);
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    int w0, exp_n;
    do_reset();
    w0 = wr_cnt;
    build_rand(v.ni, v.nd);
    exp_n = exp_q.size();
    pulse_start();
    send(v.tog);
    finish_load(v.err);
    check("write_count", 32'(wr_cnt - w0), 32'(exp_n));
  endtask

  vec_t vt[6];

  initial begin
    int w0;
    bus.s_valid = 1'b0;
    bus.s_data  = 32'h0;
`ifndef LOADER_VERIFY_EN
    bus.imem_rdata = 32'h0;
    bus.dmem_rdata = 32'h0;
`endif
    vt[0] = '{2, 1, 1'b0, 1'b0};
    vt[1] = '{3, 0, 1'b1, 1'b0};
    vt[2] = '{0, 2, 1'b0, 1'b0};
    vt[3] = '{513, 1, 1'b0, 1'b1};
    vt[4] = '{512, 1024, 1'b0, 1'b0};
    vt[5] = '{5, 1025, 1'b1, 1'b1};

    // reset state
    @(posedge clk); @(negedge clk);
    check("rst_outputs", {26'b0, cpu_enable, busy, done, error, bus.s_ready, bus.imem_wen | bus.dmem_wen}, 32'd0);
    @(posedge clk); #1;
    arst = 1'b0;

    // async reset mid LOAD_I, then a clean reload
    build_rand(4, 1);
    pulse_start();
    bus.s_valid = 1'b1; bus.s_data = stream_q[0];
    @(posedge clk); #1;
    bus.s_data = stream_q[1];
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    check("mid_load_busy", {31'b0, busy}, 32'd1);
    arst = 1'b1;
    @(negedge clk);
    check("arst_outputs", {26'b0, cpu_enable, busy, done, error, bus.s_ready, bus.imem_wen | bus.dmem_wen}, 32'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    exp_q.delete();
    build_rand(3, 2);
    pulse_start();
    send(1'b0);
    finish_load(1'b0);

    // reference stream, valid held high, with latency
    do_reset();
    w0 = wr_cnt;
    build_fixed();
    pulse_start();
    send(1'b0);
    finish_load(1'b0);
    check("done_latency", 32'(done_cyc - first_acc), 32'(DONE_LAT));
    check("ref_writes", 32'(wr_cnt - w0), 32'd3);

    // same stream with valid toggling, then start ignored in RUN, stop, restart
    do_reset();
    w0 = wr_cnt;
    build_fixed();
    pulse_start();
    send(1'b1);
    finish_load(1'b0);
    check("toggle_writes", 32'(wr_cnt - w0), 32'd3);
    pulse_start();
    @(negedge clk);
    check("start_in_run_enable", {31'b0, cpu_enable}, 32'd1);
    check("start_in_run_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    check("stop_enable", {31'b0, cpu_enable}, 32'd0);
    check("stop_idle_busy", {31'b0, busy}, 32'd0);
    check("stop_idle_ready", {31'b0, bus.s_ready}, 32'd0);
    @(posedge clk); #1;
    build_rand(2, 3);
    pulse_start();
    send(1'b1);
    finish_load(1'b0);

    // stop during header is ignored
    do_reset();
    build_rand(2, 2);
    pulse_start();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    check("stop_in_hdr_busy", {31'b0, busy}, 32'd1);
    check("stop_in_hdr_ready", {31'b0, bus.s_ready}, 32'd1);
    @(posedge clk); #1;
    send(1'b0);
    finish_load(1'b0);

    foreach (vt[i]) run_vec(vt[i]);

`ifdef LOADER_VERIFY_EN
    corrupt_en = 1'b1;
    run_vec('{3, 1, 1'b0, 1'b1});
    corrupt_en = 1'b0;
    run_vec('{3, 1, 1'b0, 1'b0});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
